// File: rtl/fifo_wr_traffic_gen_if.sv
// fifo_wr_traffic_gen_if: handshake and status bundle between the write-side
// traffic generator and its consumer (FIFO write port plus control).
//   start   run request, one cycle, honoured only while idle
//   mode    0 = linear pattern, 1 = LFSR pattern; captured with start
//   full    FIFO full flag, write domain
//   wr      FIFO write enable
//   datain  FIFO write data, WIDTH bits
//   busy    run in progress
//   done    one-cycle completion pulse
//   sent    words accepted in the current or last run, CW bits
// master: the generator. slave: the side that supplies start/mode/full.
interface fifo_wr_traffic_gen_if #(
   parameter int unsigned WIDTH = 36,
   parameter int unsigned CW    = 11
);
   logic             start;
   logic             mode;
   logic             full;
   logic             wr;
   logic [WIDTH-1:0] datain;
   logic             busy;
   logic             done;
   logic [CW-1:0]    sent;

   modport master (
      input  start, mode, full,
      output wr, datain, busy, done, sent
   );

   modport slave (
      output start, mode, full,
      input  wr, datain, busy, done, sent
   );
endinterface

// File: rtl/fifo_wr_traffic_gen.sv
// fifo_wr_traffic_gen: write-domain traffic source for the async FIFO wrapper.
// A start pulse in idle launches a run of COUNT words, linear (1, 2, 3, ...) or
// drawn from a 32-bit Galois LFSR, honouring full back-pressure.
// Ports:
//   wrclk  write-domain clock
//   reset  synchronous, active-high
//   bus    fifo_wr_traffic_gen_if.master (start/mode/full in;
//          wr/datain/busy/done/sent out)
// Optional feature: define FIFO_WR_GEN_THROTTLE_EN to gate wr with a 16-bit
// Fibonacci LFSR, inserting roughly 25% idle cycles without changing data.
module fifo_wr_traffic_gen #(
   parameter int unsigned WIDTH     = 36,
   parameter int unsigned COUNT     = 1024,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_2024,
   parameter int unsigned CW        = $clog2(COUNT + 1)
) (
   input logic                   wrclk,
   input logic                   reset,
   fifo_wr_traffic_gen_if.master bus
);

   // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
   localparam logic [31:0] SeedEff  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
   localparam logic [31:0] TapMask  = 32'h8020_0003;
   localparam logic [CW-1:0] CountC = CW'(COUNT);
   localparam logic [CW-1:0] LastC  = CW'(COUNT - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic             busy_q;
   logic             done_q;
   logic             mode_q;
   logic [CW-1:0]    sent_q;
   logic [WIDTH-1:0] data_q;
   logic [31:0]      lfsr_q;
   logic [31:0]      lfsr_nxt;
   logic             gate;
   logic             wr;

   function automatic logic [WIDTH-1:0] rep_word(input logic [31:0] l);
      logic [63:0] r;
      r = {l, l};
      return r[WIDTH-1:0];
   endfunction

   // Right-shifting Galois step.
   always_comb begin
      lfsr_nxt = {1'b0, lfsr_q[31:1]};
      if (lfsr_q[0]) begin
         lfsr_nxt = lfsr_nxt ^ TapMask;
      end
   end

`ifdef FIFO_WR_GEN_THROTTLE_EN
   logic [15:0] thr_q;

   always_ff @(posedge wrclk) begin
      if (reset) begin
         thr_q <= 16'hBEEF;
      end else if (state_q == StRun) begin
         thr_q <= {thr_q[14:0], thr_q[15] ^ thr_q[13] ^ thr_q[12] ^ thr_q[10]};
      end
   end

   assign gate = (thr_q[1:0] != 2'b00);
`else
   assign gate = 1'b1;
`endif

   // Combinational so that full rising blocks the write in the same cycle.
   assign wr = (state_q == StRun) & ~bus.full & (sent_q < CountC) & gate;

   always_ff @(posedge wrclk) begin
      if (reset) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mode_q  <= 1'b0;
         sent_q  <= '0;
         data_q  <= '0;
         lfsr_q  <= SeedEff;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q <= StRun;
                  busy_q  <= 1'b1;
                  mode_q  <= bus.mode;
                  sent_q  <= '0;
                  data_q  <= bus.mode ? rep_word(lfsr_q) : WIDTH'(1);
               end
            end
            StRun: begin
               if (wr) begin
                  sent_q <= sent_q + CW'(1);
                  // Advance to the next word on the edge that accepts this one.
                  if (mode_q) begin
                     lfsr_q <= lfsr_nxt;
                     data_q <= rep_word(lfsr_nxt);
                  end else begin
                     data_q <= data_q + WIDTH'(1);
                  end
                  if (sent_q == LastC) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wr     = wr;
   assign bus.datain = data_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.sent   = sent_q;

endmodule

// File: tb/tb_fifo_wr_traffic_gen.sv
// Bench for fifo_wr_traffic_gen with default parameters (WIDTH 36, COUNT 1024).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge against a word-index model of the run.
module tb_fifo_wr_traffic_gen;
   localparam int unsigned WIDTH = 36;
   localparam int unsigned COUNT = 1024;
   localparam int unsigned CW    = $clog2(COUNT + 1);
   localparam logic [31:0] SEED  = 32'hACE1_2024;

   logic wrclk;
   logic reset;

   fifo_wr_traffic_gen_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

   fifo_wr_traffic_gen #(
      .WIDTH     (WIDTH),
      .COUNT     (COUNT),
      .LFSR_SEED (SEED)
   ) dut (
      .wrclk (wrclk),
      .reset (reset),
      .bus   (bus)
   );

   initial wrclk = 1'b0;
   always #5 wrclk = ~wrclk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a run is an index k of the next word to deliver plus the LFSR value
   // backing that word in random mode.
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   bit          m_mode = 1'b0;
   int          m_sent = 0;
   logic [31:0] m_lfsr = SEED;

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [WIDTH-1:0] exp_word();
      logic [63:0] r;
      r = {m_lfsr, m_lfsr};
      if (m_mode) return r[WIDTH-1:0];
      return WIDTH'(m_sent + 1);
   endfunction

   always @(posedge wrclk) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_sent <= 0;
         m_lfsr <= SEED;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (!m_busy) begin
         if (bus.start) begin
            m_busy <= 1'b1;
            m_mode <= bus.mode;
            m_sent <= 0;
         end
      end else if (!bus.full && m_sent < COUNT) begin
         m_sent <= m_sent + 1;
         if (m_mode) m_lfsr <= lfsr_step(m_lfsr);
         if (m_sent + 1 == COUNT) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
         end
      end
   end

   bit               check_en = 1'b0;
   int               done_cnt = 0;
   int               wr_cnt   = 0;
   bit               cap_en   = 1'b0;
   int               cap_n    = 0;
   logic [WIDTH-1:0] cap [3];

   always @(negedge wrclk) begin
      if (check_en) begin
         chk("wr", 64'(bus.wr), 64'(m_busy && !bus.full && m_sent < COUNT));
         chk("busy", 64'(bus.busy), 64'(m_busy));
         chk("done", 64'(bus.done), 64'(m_done));
         chk("sent", 64'(bus.sent), 64'(m_sent));
         if (m_busy && m_sent < COUNT) chk("datain", 64'(bus.datain), 64'(exp_word()));
         if (bus.done) done_cnt++;
         if (bus.wr) wr_cnt++;
         if (cap_en && bus.wr && cap_n < 3) begin
            cap[cap_n] = bus.datain;
            cap_n++;
         end
      end
   end

   task automatic step();
      @(posedge wrclk);
      #1;
   endtask

   task automatic pulse_start(input logic md);
      bus.start = 1'b1;
      bus.mode  = md;
      step();
      bus.start = 1'b0;
      bus.mode  = ~md;  // later mode changes must be ignored
   endtask

   task automatic wait_sent(input int target, input string nm);
      int n = 0;
      while (!(m_busy && m_sent == target) && n < 3000) begin
         step();
         n++;
      end
      chk(nm, 64'(n < 3000), 64'd1);
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (!m_done && n < 3000) begin
         step();
         n++;
      end
      chk(nm, 64'(n < 3000), 64'd1);
   endtask

   initial begin
      int d0;
      int w0;
      int idle_wr;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.full  = 1'b0;
      step();
      check_en = 1'b1;
      step();
      step();
      reset = 1'b0;

      // Idle after reset: nothing moves for 50 cycles.
      idle_wr = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus.wr) idle_wr++;
      end
      chk("idle_no_wr", 64'(idle_wr), 64'd0);
      chk("idle_datain", 64'(bus.datain), 64'd0);
      chk("idle_busy", 64'(bus.busy), 64'd0);
      chk("idle_sent", 64'(bus.sent), 64'd0);

      // Linear run with a 10-cycle stall on word 500.
      d0 = done_cnt;
      w0 = wr_cnt;
      pulse_start(1'b0);
      chk("lin_first_word", 64'(bus.datain), 64'd1);
      chk("lin_first_wr", 64'(bus.wr), 64'd1);
      wait_sent(499, "lin_reach_500");
      bus.full = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("lin_stall_hold", 64'(bus.datain), 64'd500);
      chk("lin_stall_wr", 64'(bus.wr), 64'd0);
      bus.full = 1'b0;
      wait_done("lin_completes");
      step();
      step();
      chk("lin_done_once", 64'(done_cnt - d0), 64'd1);
      chk("lin_wr_count", 64'(wr_cnt - w0), 64'd1024);
      chk("lin_sent_final", 64'(bus.sent), 64'd1024);

      // Reset to reseed the LFSR, then a random run with a 5-cycle stall.
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      cap_en = 1'b1;
      cap_n  = 0;
      d0     = done_cnt;
      pulse_start(1'b1);
      wait_sent(1, "rnd_reach_1");
      bus.full = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("rnd_stall_hold", 64'(bus.datain), 64'h2_5670_9012);
      bus.full = 1'b0;
      wait_done("rnd_completes");
      step();
      cap_en = 1'b0;
      chk("rnd_word0", 64'(cap[0]), 64'h4_ACE1_2024);
      chk("rnd_word1", 64'(cap[1]), 64'h2_5670_9012);
      chk("rnd_word2", 64'(cap[2]), 64'h9_2B38_4809);
      chk("rnd_done_once", 64'(done_cnt - d0), 64'd1);

      // Reset in the middle of a linear run abandons it without a done pulse.
      d0 = done_cnt;
      pulse_start(1'b0);
      wait_sent(300, "rst_reach_300");
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_sent", 64'(bus.sent), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      step();
      chk("rst_no_done", 64'(done_cnt - d0), 64'd0);

      // Restart linear; start pulses in RUN and DONE are ignored.
      d0 = done_cnt;
      pulse_start(1'b0);
      chk("restart_first_word", 64'(bus.datain), 64'd1);
      wait_sent(100, "ign_reach_100");
      pulse_start(1'b1);
      wait_done("ign_completes");
      pulse_start(1'b1);
      for (int i = 0; i < 4; i++) step();
      chk("ign_done_once", 64'(done_cnt - d0), 64'd1);
      chk("ign_busy_after", 64'(bus.busy), 64'd0);
      chk("ign_sent_kept", 64'(bus.sent), 64'd1024);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
